// File: rtl/router_pkg.sv
// router_pkg
// Shared definitions for the router packet register stage:
//   CHK_XOR / CHK_SUM  - check-word algorithm selectors
//   HDR_MAX_W          - widest header word the field helpers accept
//   hdr_field_addr()   - destination address field of a header word
//   hdr_field_len()    - payload length field of a header word
package router_pkg;

  localparam int CHK_XOR = 0;
  localparam int CHK_SUM = 1;

  localparam int HDR_MAX_W = 64;

  // Address sits in the low addr_w bits of the header.
  function automatic logic [HDR_MAX_W-1:0] hdr_field_addr(
    input logic [HDR_MAX_W-1:0] word,
    input int                   addr_w
  );
    logic [HDR_MAX_W-1:0] mask;
    mask = (64'd1 << addr_w) - 64'd1;
    return word & mask;
  endfunction

  // Length sits directly above the address field, len_w bits wide.
  function automatic logic [HDR_MAX_W-1:0] hdr_field_len(
    input logic [HDR_MAX_W-1:0] word,
    input int                   len_w,
    input int                   addr_w
  );
    logic [HDR_MAX_W-1:0] mask;
    mask = (64'd1 << len_w) - 64'd1;
    return (word >> addr_w) & mask;
  endfunction

endpackage

// File: rtl/router_chk_acc.sv
// router_chk_acc
// Running check accumulator for one packet.
//   clk, reset  - clock, asynchronous active-high reset
//   clear       - zero the accumulator (start of packet)
//   fold_en     - fold fold_data into the accumulator this cycle
//   fold_data   - word to fold
//   acc         - current accumulated check value
// CHK_MODE selects XOR parity (CHK_XOR) or sum modulo 2**DATA_W (CHK_SUM).
module router_chk_acc
  import router_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CHK_MODE = CHK_XOR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              fold_en,
  input  logic [DATA_W-1:0] fold_data,
  output logic [DATA_W-1:0] acc
);

  // Clear wins over fold so a new packet always starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (fold_en) begin
      if (CHK_MODE == CHK_SUM) begin
        acc <= acc + fold_data;
      end else begin
        acc <= acc ^ fold_data;
      end
    end
  end

endmodule

// File: rtl/router_pkt_reg.sv
// router_pkt_reg
// Packet register stage between the router input port and the destination
// FIFOs. Latches and validates the header, forwards header and payload words,
// parks one word while the FIFO is full, captures the trailing check word and
// flags check, length and address errors.
//   clk, reset                  - clock, asynchronous active-high reset
//   packet_valid, datain        - incoming word stream
//   fifo_full                   - selected destination FIFO is full
//   detect_add .. full_state    - one-hot router FSM state strobes
//   rst_int_reg                 - clears low_packet_valid
//   dout                        - word presented to the FIFO
//   parity_done                 - check word captured
//   low_packet_valid            - packet_valid fell during load
//   err, len_err, addr_err      - check / length / address error flags
//   hdr_addr, hdr_len           - latched header fields
module router_pkt_reg
  import router_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int LEN_W    = 6,
  parameter int ADDR_W   = 2,
  parameter int NUM_DEST = 3,
  parameter int CHK_MODE = CHK_XOR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              packet_valid,
  input  logic [DATA_W-1:0] datain,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              parity_done,
  output logic              low_packet_valid,
  output logic              err,
  output logic              len_err,
  output logic              addr_err,
  output logic [ADDR_W-1:0] hdr_addr,
  output logic [LEN_W-1:0]  hdr_len
);

  logic [HDR_MAX_W-1:0] word_ext;
  logic [ADDR_W-1:0]    in_addr;
  logic [LEN_W-1:0]     in_len;
  logic                 addr_ok;

  logic [DATA_W-1:0]    hdr_word;
  logic [DATA_W-1:0]    hold_reg;
  logic [DATA_W-1:0]    chk_reg;
  logic [DATA_W-1:0]    acc;
  logic [DATA_W-1:0]    fold_data;
  logic [LEN_W:0]       count;
  logic                 parity_done_q;

  logic                 capture;
  logic                 chk_from_ld;
  logic                 chk_from_laf;
  logic                 fold_en;
  logic                 chk_eval;

  assign word_ext = HDR_MAX_W'(datain);
  assign in_addr  = ADDR_W'(hdr_field_addr(word_ext, ADDR_W));
  assign in_len   = LEN_W'(hdr_field_len(word_ext, LEN_W, ADDR_W));
  assign addr_ok  = int'(in_addr) < NUM_DEST;

  assign capture      = ld_state && packet_valid && !full_state;
  assign chk_from_ld  = ld_state && !fifo_full && !packet_valid;
  assign chk_from_laf = laf_state && low_packet_valid && !parity_done;

  // Errors are evaluated exactly once per packet, one cycle after the
  // check word lands, so acc and count already include every payload word.
  assign chk_eval = parity_done && !parity_done_q;

  // The header is folded during lfd; payload words are folded as captured.
  assign fold_en   = lfd_state || capture;
  assign fold_data = lfd_state ? hdr_word : datain;

  router_chk_acc #(
    .DATA_W   (DATA_W),
    .CHK_MODE (CHK_MODE)
  ) u_chk_acc (
    .clk       (clk),
    .reset     (reset),
    .clear     (detect_add),
    .fold_en   (fold_en),
    .fold_data (fold_data),
    .acc       (acc)
  );

  // An out-of-range header leaves the previously latched header untouched
  // so downstream logic never sees an address it cannot route.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_word <= '0;
      hdr_addr <= '0;
      hdr_len  <= '0;
      addr_err <= 1'b0;
    end else if (detect_add && packet_valid) begin
      if (addr_ok) begin
        hdr_word <= datain;
        hdr_addr <= in_addr;
        hdr_len  <= in_len;
        addr_err <= 1'b0;
      end else begin
        addr_err <= 1'b1;
      end
    end
  end

  // Output word select; during a FIFO-full stall the word is parked in
  // hold_reg and replayed in laf while dout keeps its last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout     <= '0;
      hold_reg <= '0;
    end else if (lfd_state) begin
      dout <= hdr_word;
    end else if (ld_state) begin
      if (fifo_full) begin
        hold_reg <= datain;
      end else begin
        dout <= datain;
      end
    end else if (laf_state) begin
      dout <= hold_reg;
    end
  end

  // Payload counter saturates rather than wrapping so an over-long packet
  // can never alias back onto a valid length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (detect_add) begin
      count <= '0;
    end else if (capture && (count != '1)) begin
      count <= count + (LEN_W+1)'(1);
    end
  end

  // Set has priority over rst_int_reg.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      low_packet_valid <= 1'b0;
    end else if (ld_state && !packet_valid) begin
      low_packet_valid <= 1'b1;
    end else if (rst_int_reg) begin
      low_packet_valid <= 1'b0;
    end
  end

  // When the check word arrived during a stall it was parked in hold_reg,
  // so the laf path takes it from there rather than from the live input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_reg       <= '0;
      parity_done   <= 1'b0;
      parity_done_q <= 1'b0;
      err           <= 1'b0;
      len_err       <= 1'b0;
    end else begin
      parity_done_q <= parity_done;
      if (detect_add) begin
        parity_done <= 1'b0;
        err         <= 1'b0;
        len_err     <= 1'b0;
      end else begin
        if (chk_from_ld) begin
          chk_reg     <= datain;
          parity_done <= 1'b1;
        end else if (chk_from_laf) begin
          chk_reg     <= hold_reg;
          parity_done <= 1'b1;
        end
        if (chk_eval) begin
          err     <= (acc != chk_reg);
          len_err <= (count != {1'b0, hdr_len});
        end
      end
    end
  end

endmodule

// File: tb/tb_router_pkt_reg.sv
// tb_router_pkt_reg
// Directed bench for router_pkt_reg: one XOR-parity instance and one
// additive-checksum instance share the same stimulus.
module tb_router_pkt_reg;
  import router_pkg::*;

  localparam logic [4:0] S_IDLE = 5'b00000;
  localparam logic [4:0] S_DET  = 5'b10000;
  localparam logic [4:0] S_LFD  = 5'b01000;
  localparam logic [4:0] S_LD   = 5'b00100;
  localparam logic [4:0] S_LAF  = 5'b00010;
  localparam logic [4:0] S_FULL = 5'b00001;

  logic       clk = 1'b0;
  logic       reset;
  logic       packet_valid;
  logic [7:0] datain;
  logic       fifo_full;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg;

  logic [7:0] dout, dout_s;
  logic       parity_done, low_packet_valid, err, len_err, addr_err;
  logic       parity_done_s, low_packet_valid_s, err_s, len_err_s, addr_err_s;
  logic [1:0] hdr_addr, hdr_addr_s;
  logic [5:0] hdr_len, hdr_len_s;

  int errors = 0;
  int checks = 0;

  logic [7:0] payload [0:15];

  always #5 clk = ~clk;

  router_pkt_reg #(.DATA_W(8), .LEN_W(6), .ADDR_W(2), .NUM_DEST(3), .CHK_MODE(CHK_XOR)) dut (
    .clk(clk), .reset(reset), .packet_valid(packet_valid), .datain(datain),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout), .parity_done(parity_done),
    .low_packet_valid(low_packet_valid), .err(err), .len_err(len_err),
    .addr_err(addr_err), .hdr_addr(hdr_addr), .hdr_len(hdr_len)
  );

  router_pkt_reg #(.DATA_W(8), .LEN_W(6), .ADDR_W(2), .NUM_DEST(3), .CHK_MODE(CHK_SUM)) dut_sum (
    .clk(clk), .reset(reset), .packet_valid(packet_valid), .datain(datain),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout_s), .parity_done(parity_done_s),
    .low_packet_valid(low_packet_valid_s), .err(err_s), .len_err(len_err_s),
    .addr_err(addr_err_s), .hdr_addr(hdr_addr_s), .hdr_len(hdr_len_s)
  );

  // State strobes must stay one-hot (or all low).
  always @(negedge clk) begin
    assert ($onehot0({detect_add, lfd_state, ld_state, laf_state, full_state}))
    else begin
      errors++;
      $error("[TB] FAIL onehot strobes observed=%05b", {detect_add, lfd_state, ld_state, laf_state, full_state});
    end
  end

  task automatic applyStimulus(input logic [4:0] strobes, input logic pv,
                               input logic [7:0] data, input logic ff, input logic rii);
    {detect_add, lfd_state, ld_state, laf_state, full_state} = strobes;
    packet_valid = pv;
    datain       = data;
    fifo_full    = ff;
    rst_int_reg  = rii;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] xorOf(input logic [7:0] hdr, input int n);
    logic [7:0] p;
    p = hdr;
    for (int i = 0; i < n; i++) p = p ^ payload[i];
    return p;
  endfunction

  // Header, lfd, n payload words, then the check word with packet_valid low.
  // Leaves the strobes idle with parity_done just raised.
  task automatic runPacket(input string tag, input logic [7:0] hdr, input int n, input logic [7:0] chk);
    applyStimulus(S_DET, 1'b1, hdr, 1'b0, 1'b1);
    checkOutput({tag, " low_pv cleared"}, 32'(low_packet_valid), 32'd0);
    checkOutput({tag, " parity_done cleared"}, 32'(parity_done), 32'd0);
    applyStimulus(S_LFD, 1'b1, payload[0], 1'b0, 1'b0);
    checkOutput({tag, " dout header"}, 32'(dout), 32'(hdr));
    for (int i = 0; i < n; i++) begin
      applyStimulus(S_LD, 1'b1, payload[i], 1'b0, 1'b0);
      checkOutput($sformatf("%s dout p%0d", tag, i), 32'(dout), 32'(payload[i]));
    end
    applyStimulus(S_LD, 1'b0, chk, 1'b0, 1'b0);
    checkOutput({tag, " parity_done"}, 32'(parity_done), 32'd1);
    checkOutput({tag, " dout chk"}, 32'(dout), 32'(chk));
    checkOutput({tag, " low_pv"}, 32'(low_packet_valid), 32'd1);
    applyStimulus(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    payload[0] = 8'h15; payload[1] = 8'hA3; payload[2] = 8'h7C; payload[3] = 8'h01;
    payload[4] = 8'hF0; payload[5] = 8'h3E; payload[6] = 8'h99; payload[7] = 8'h42;
    for (int i = 8; i < 16; i++) payload[i] = 8'h00;

    reset = 1'b1;
    {detect_add, lfd_state, ld_state, laf_state, full_state} = S_IDLE;
    packet_valid = 1'b0; datain = 8'h00; fifo_full = 1'b0; rst_int_reg = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset dout", 32'(dout), 32'd0);
    checkOutput("reset flags", 32'({parity_done, low_packet_valid, err, len_err, addr_err}), 32'd0);
    checkOutput("reset hdr", 32'({hdr_addr, hdr_len}), 32'd0);
    reset = 1'b0;

    // Good XOR packet, header 0x22: len 8, addr 2. Parity 0xFC.
    $display("[TB] good xor packet");
    checkOutput("xorOf sanity", 32'(xorOf(8'h22, 8)), 32'hFC);
    runPacket("good", 8'h22, 8, 8'hFC);
    checkOutput("good hdr_len", 32'(hdr_len), 32'd8);
    checkOutput("good hdr_addr", 32'(hdr_addr), 32'd2);
    checkOutput("good addr_err", 32'(addr_err), 32'd0);
    checkOutput("good err", 32'(err), 32'd0);
    checkOutput("good len_err", 32'(len_err), 32'd0);
    checkOutput("sum inst err on xor word", 32'(err_s), 32'd1);

    // Inverted parity word: err set and sticky until the next detect_add.
    $display("[TB] bad parity packet");
    runPacket("badpar", 8'h22, 8, 8'h03);
    checkOutput("badpar err", 32'(err), 32'd1);
    checkOutput("badpar len_err", 32'(len_err), 32'd0);
    applyStimulus(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("badpar err sticky", 32'(err), 32'd1);
    checkOutput("rst_int_reg clears low_pv", 32'(low_packet_valid), 32'd0);

    // Short packet: 6 payload words against a length of 8.
    $display("[TB] short packet");
    runPacket("short", 8'h22, 6, xorOf(8'h22, 6));
    checkOutput("short len_err", 32'(len_err), 32'd1);
    checkOutput("short err", 32'(err), 32'd0);

    // Out-of-range address 3, then valid address 1.
    $display("[TB] address validation");
    applyStimulus(S_DET, 1'b1, 8'h23, 1'b0, 1'b0);
    checkOutput("addr3 addr_err", 32'(addr_err), 32'd1);
    checkOutput("addr3 hdr_addr kept", 32'(hdr_addr), 32'd2);
    checkOutput("addr3 err cleared", 32'(err | len_err), 32'd0);
    applyStimulus(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(S_DET, 1'b1, 8'h21, 1'b0, 1'b0);
    checkOutput("addr1 addr_err", 32'(addr_err), 32'd0);
    checkOutput("addr1 hdr_addr", 32'(hdr_addr), 32'd1);
    checkOutput("addr1 hdr_len", 32'(hdr_len), 32'd8);

    // FIFO-full stall on payload word 4 (payload[3]) for three cycles.
    $display("[TB] fifo full stall");
    applyStimulus(S_LFD, 1'b1, payload[0], 1'b0, 1'b0);
    checkOutput("stall dout header", 32'(dout), 32'h21);
    for (int i = 0; i < 3; i++) applyStimulus(S_LD, 1'b1, payload[i], 1'b0, 1'b0);
    checkOutput("stall dout word3", 32'(dout), 32'(payload[2]));
    applyStimulus(S_LD, 1'b1, payload[3], 1'b1, 1'b0);
    checkOutput("stall c1 dout", 32'(dout), 32'(payload[2]));
    applyStimulus(S_FULL, 1'b1, payload[4], 1'b1, 1'b0);
    checkOutput("stall c2 dout", 32'(dout), 32'(payload[2]));
    applyStimulus(S_FULL, 1'b1, payload[4], 1'b1, 1'b0);
    checkOutput("stall c3 dout", 32'(dout), 32'(payload[2]));
    applyStimulus(S_LAF, 1'b1, payload[4], 1'b0, 1'b0);
    checkOutput("laf dout word4", 32'(dout), 32'(payload[3]));
    for (int i = 4; i < 8; i++) applyStimulus(S_LD, 1'b1, payload[i], 1'b0, 1'b0);
    checkOutput("stall dout word8", 32'(dout), 32'(payload[7]));
    applyStimulus(S_LD, 1'b0, xorOf(8'h21, 8), 1'b0, 1'b0);
    checkOutput("stall parity_done", 32'(parity_done), 32'd1);
    applyStimulus(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("stall err", 32'(err), 32'd0);
    checkOutput("stall len_err", 32'(len_err), 32'd0);

    // Checksum instance: 0x0A + 0xFF + 0x02 wraps to 0x0B.
    $display("[TB] modular sum");
    payload[0] = 8'hFF; payload[1] = 8'h02;
    runPacket("sum", 8'h0A, 2, 8'h0B);
    checkOutput("sum hdr_len", 32'(hdr_len_s), 32'd2);
    checkOutput("sum hdr_addr", 32'(hdr_addr_s), 32'd2);
    checkOutput("sum err", 32'(err_s), 32'd0);
    checkOutput("sum len_err", 32'(len_err_s), 32'd0);
    checkOutput("sum parity_done", 32'(parity_done_s), 32'd1);
    checkOutput("xor inst err on sum word", 32'(err), 32'd1);

    // Reset after payload word 3, then a clean packet.
    $display("[TB] reset mid packet");
    payload[0] = 8'h15; payload[1] = 8'hA3;
    applyStimulus(S_DET, 1'b1, 8'h22, 1'b0, 1'b0);
    applyStimulus(S_LFD, 1'b1, payload[0], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(S_LD, 1'b1, payload[i], 1'b0, 1'b0);
    checkOutput("pre-reset dout", 32'(dout), 32'(payload[2]));
    reset = 1'b1;
    #2;
    checkOutput("midreset dout", 32'(dout), 32'd0);
    checkOutput("midreset hdr", 32'({hdr_addr, hdr_len}), 32'd0);
    checkOutput("midreset flags", 32'({parity_done, low_packet_valid, err, len_err, addr_err}), 32'd0);
    checkOutput("midreset sum dout", 32'(dout_s), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    runPacket("clean", 8'h22, 8, 8'hFC);
    checkOutput("clean err", 32'(err), 32'd0);
    checkOutput("clean len_err", 32'(len_err), 32'd0);
    checkOutput("clean hdr_len", 32'(hdr_len), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
